// File: rtl/dmem_line_responder_pkg.sv
// Shared definitions for the data-memory line responder: line geometry,
// default access latency and the FSM state encoding.
package dmem_pkg;

  localparam int LINE_W          = 256;
  localparam int OFFSET_W        = 5;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_line_responder_if.sv
// Line-transfer bus between the data cache (master) and the data memory (slave).
// Signal names are taken from the memory side of the link.
interface dmem_line_responder_if;
  import dmem_pkg::*;

  logic              enable_i;
  logic              write_i;
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/dmem_line_ram.sv
// Single-port DEPTH x LINE_W line store with a registered read port.
// The read register only changes on a read access, so it doubles as the held read line.
module dmem_line_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Data-memory end of the 256-bit cache line interface: one line read or write
// per request, fixed access latency, one-cycle acknowledge on completion.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dmem_line_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  dmem_state_e       state_q;
  logic [CNT_W-1:0]  counter_q;
  logic              reqWrite_q;
  logic [IDX_W-1:0]  reqIdx_q;
  logic [LINE_W-1:0] reqData_q;
  logic              ack_q;

  logic [IDX_W-1:0]  reqIdx_d;
  logic              ramEn;
  logic [LINE_W-1:0] ramRdata;
  logic              unusedAddrBits;

  // Upper address bits alias modulo DEPTH; the byte offset is irrelevant for whole lines.
  assign reqIdx_d       = bus.addr_i[OFFSET_W +: IDX_W];
  assign unusedAddrBits = ^{bus.addr_i[OFFSET_W-1:0], bus.addr_i[31:OFFSET_W+IDX_W]};

  // ACK is the last cycle of an access: the array is touched and ack_o registered on
  // the edge leaving it, so ack_o and the read line appear together while already IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      counter_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= (state_q == ACK);
      unique case (state_q)
        IDLE: begin
          if (bus.enable_i) begin
            reqWrite_q <= bus.write_i;
            reqIdx_q   <= reqIdx_d;
            reqData_q  <= bus.data_i;
            counter_q  <= CNT_W'(LATENCY - 1);
            state_q    <= (LATENCY == 1) ? ACK : BUSY;
          end
        end
        BUSY: begin
          counter_q <= counter_q - 1'b1;
          if (counter_q == CNT_W'(1)) begin
            state_q <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset in the ACK cycle suppresses the array access, aborting the request cleanly.
  assign ramEn = (state_q == ACK) && !rst_i;

  dmem_line_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (ramEn),
    .we_i    (reqWrite_q),
    .addr_i  (reqIdx_q),
    .wdata_i (reqData_q),
    .rdata_o (ramRdata)
  );

  assign bus.ack_o  = ack_q;
  assign bus.data_o = ramRdata;

  enableHeldWhileBusy: assert property (
    @(posedge clk_i) disable iff (rst_i) (state_q == BUSY) |-> bus.enable_i
  );

endmodule
